// File: rtl/cnt_down_timer_if.sv
// Handshake and status bundle for cnt_down_timer.
// The master side drives load/start/enable/abort; the slave side is the timer.
interface cnt_down_timer_if #(
   parameter int unsigned CNT_WIDTH = 8
);
   logic                 cnt_load_valid;
   logic [CNT_WIDTH-1:0] cnt_load_val;
   logic                 cnt_load_ready;
   logic                 cnt_start;
   logic                 cnt_en;
   logic                 cnt_abort;
   logic [CNT_WIDTH-1:0] cnt_o;
   logic                 cnt_busy;
   logic                 cnt_done;

   modport master (
      output cnt_load_valid, cnt_load_val, cnt_start, cnt_en, cnt_abort,
      input  cnt_load_ready, cnt_o, cnt_busy, cnt_done
   );

   modport slave (
      input  cnt_load_valid, cnt_load_val, cnt_start, cnt_en, cnt_abort,
      output cnt_load_ready, cnt_o, cnt_busy, cnt_done
   );
endinterface

// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer with a registered one-cycle terminal pulse.
// Define CNT_AUTO_RELOAD_EN to reload from the reload register at terminal count.
module cnt_down_timer #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic            cnt_clk,
   input  logic            cnt_rst_n,
   cnt_down_timer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] reload_q, reload_d;
   logic                 done_q, done_d;
   logic                 load_acc;

   assign load_acc = bus.cnt_load_valid && (state_q != StRun);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (bus.cnt_abort) begin
         // Reload register survives an abort.
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (load_acc) begin
                  cnt_d    = bus.cnt_load_val;
                  reload_d = bus.cnt_load_val;
                  state_d  = StArmed;
               end
            end
            StArmed: begin
               if (load_acc) begin
                  cnt_d    = bus.cnt_load_val;
                  reload_d = bus.cnt_load_val;
               end else if (bus.cnt_start) begin
                  if (cnt_q == '0) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StRun;
                  end
               end
            end
            StRun: begin
               if (bus.cnt_en) begin
                  if (cnt_q > CNT_WIDTH'(1)) begin
                     cnt_d = cnt_q - CNT_WIDTH'(1);
                  end else if (cnt_q == CNT_WIDTH'(1)) begin
                     cnt_d  = '0;
                     done_d = 1'b1;
`ifdef CNT_AUTO_RELOAD_EN
                     if (reload_q == '0) state_d = StIdle;
`else
                     state_d = StIdle;
`endif
                  end else begin
`ifdef CNT_AUTO_RELOAD_EN
                     // Sitting at zero after a terminal pulse: restart the interval.
                     cnt_d  = (reload_q == '0) ? '0 : reload_q - CNT_WIDTH'(1);
                     done_d = (reload_q <= CNT_WIDTH'(1));
                     if (reload_q == '0) state_d = StIdle;
`else
                     state_d = StIdle;
`endif
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign bus.cnt_o          = cnt_q;
   assign bus.cnt_busy       = (state_q == StRun);
   assign bus.cnt_load_ready = (state_q != StRun);
   assign bus.cnt_done       = done_q;

endmodule

// File: tb/tb_cnt_down_timer.sv
// Self-checking bench for cnt_down_timer; expectations come from count arithmetic
// (remaining = loaded - enabled cycles seen) rather than a state machine.
module tb_cnt_down_timer;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cnt_down_timer_if #(.CNT_WIDTH(W)) tif ();

   cnt_down_timer #(.CNT_WIDTH(W)) dut (
      .cnt_clk   (clk),
      .cnt_rst_n (rst_n),
      .bus       (tif)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit auto_rl;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      tif.cnt_load_valid = 1'b0;
      tif.cnt_load_val   = '0;
      tif.cnt_start      = 1'b0;
      tif.cnt_en         = 1'b0;
      tif.cnt_abort      = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] v);
      tif.cnt_load_valid = 1'b1;
      tif.cnt_load_val   = v;
      step();
      tif.cnt_load_valid = 1'b0;
   endtask

   task automatic cleanup();
      idle_inputs();
      tif.cnt_abort = 1'b1;
      step();
      tif.cnt_abort = 1'b0;
   endtask

   task automatic test_reset();
      logic [W+2:0] exp;
      idle_inputs();
      rst_n = 1'b0;
      #3;
      exp = {W'(0), 1'b0, 1'b0, 1'b1};
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready} !== exp)
         $display("FAIL reset_values got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready}, exp);
      else n_pass++;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [W+2:0] exp;
      load(W'(5));
      n_chk++;
      if ({tif.cnt_o, tif.cnt_load_ready, tif.cnt_busy} !== {W'(5), 1'b1, 1'b0})
         $display("FAIL basic_load got=%h want=%h",
                  {tif.cnt_o, tif.cnt_load_ready, tif.cnt_busy}, {W'(5), 1'b1, 1'b0});
      else n_pass++;
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) step();
         exp = {W'(5 - k), (k < 5) || auto_rl, (k == 5), (k == 5) ? !auto_rl : 1'b0};
         n_chk++;
         if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready} !== exp)
            $display("FAIL basic_count[%0d] got=%h want=%h", k,
                     {tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready}, exp);
         else n_pass++;
      end
      cleanup();
   endtask

   task automatic test_pause();
      int cyc;
      load(W'(4));
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      step();
      cyc = 2;
      tif.cnt_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         cyc++;
         n_chk++;
         if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done} !== {W'(3), 1'b1, 1'b0})
            $display("FAIL pause_hold[%0d] got=%h want=%h", i,
                     {tif.cnt_o, tif.cnt_busy, tif.cnt_done}, {W'(3), 1'b1, 1'b0});
         else n_pass++;
      end
      tif.cnt_en = 1'b1;
      for (int i = 0; i < 20 && tif.cnt_done !== 1'b1; i++) begin
         step();
         cyc++;
      end
      // N=4 done at s+N+1 plus three paused cycles.
      n_chk++;
      if (tif.cnt_done !== 1'b1 || cyc != 8)
         $display("FAIL pause_done_time got=%0d done=%b want=8", cyc, tif.cnt_done);
      else n_pass++;
      cleanup();
   endtask

   task automatic test_zero();
      load(W'(0));
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready} !== {W'(0), 3'b011})
         $display("FAIL zero_start got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready}, {W'(0), 3'b011});
      else n_pass++;
      step();
      n_chk++;
      if ({tif.cnt_busy, tif.cnt_done} !== 2'b00)
         $display("FAIL zero_after got=%b want=00", {tif.cnt_busy, tif.cnt_done});
      else n_pass++;
      cleanup();
   endtask

   task automatic test_abort();
      load(W'(7));
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      repeat (4) step();
      n_chk++;
      if (tif.cnt_o !== W'(3)) $display("FAIL abort_pre got=%0d want=3", tif.cnt_o);
      else n_pass++;
      tif.cnt_abort = 1'b1;
      step();
      tif.cnt_abort = 1'b0;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready} !== {W'(0), 3'b001})
         $display("FAIL abort_mid got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready}, {W'(0), 3'b001});
      else n_pass++;
      tif.cnt_start = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      n_chk++;
      if (tif.cnt_busy !== 1'b0) $display("FAIL abort_idle_start got=%b want=0", tif.cnt_busy);
      else n_pass++;
      // Abort on the terminal edge must suppress the pulse.
      load(W'(2));
      tif.cnt_start = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      step();
      tif.cnt_abort = 1'b1;
      step();
      tif.cnt_abort = 1'b0;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done} !== {W'(0), 2'b00})
         $display("FAIL abort_terminal got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_done}, {W'(0), 2'b00});
      else n_pass++;
      tif.cnt_load_valid = 1'b1;
      tif.cnt_load_val   = W'(9);
      tif.cnt_abort      = 1'b1;
      step();
      tif.cnt_abort      = 1'b0;
      tif.cnt_load_valid = 1'b0;
      tif.cnt_start      = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy} !== {W'(0), 1'b0})
         $display("FAIL abort_drops_load got=%h want=%h", {tif.cnt_o, tif.cnt_busy}, {W'(0), 1'b0});
      else n_pass++;
      cleanup();
   endtask

   task automatic test_load_start();
      tif.cnt_load_valid = 1'b1;
      tif.cnt_load_val   = W'(6);
      tif.cnt_start      = 1'b1;
      step();
      tif.cnt_load_val = W'(9);
      step();
      tif.cnt_load_valid = 1'b0;
      tif.cnt_start      = 1'b0;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_load_ready} !== {W'(9), 2'b01})
         $display("FAIL load_beats_start got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_load_ready}, {W'(9), 2'b01});
      else n_pass++;
      tif.cnt_start = 1'b1;
      step();
      tif.cnt_start      = 1'b0;
      tif.cnt_load_valid = 1'b1;
      tif.cnt_load_val   = W'(2);
      step();
      tif.cnt_load_valid = 1'b0;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_load_ready} !== {W'(9), 2'b10})
         $display("FAIL load_in_run got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_load_ready}, {W'(9), 2'b10});
      else n_pass++;
      cleanup();
   endtask

   task automatic test_random();
      int n;
      int e;
      bit en;
      logic [W+1:0] exp;
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(1, 20);
         load(W'(n));
         tif.cnt_start = 1'b1;
         tif.cnt_en    = 1'b1;
         step();
         tif.cnt_start = 1'b0;
         n_chk++;
         if ({tif.cnt_o, tif.cnt_busy} !== {W'(n), 1'b1})
            $display("FAIL rand_start[%0d] got=%h want=%h", it, {tif.cnt_o, tif.cnt_busy},
                     {W'(n), 1'b1});
         else n_pass++;
         e = 0;
         for (int c = 0; c < 200 && e < n; c++) begin
            en = ($urandom_range(0, 3) != 0);
            tif.cnt_en = en;
            step();
            if (en) e++;
            exp = {W'(n - e), (e < n) || auto_rl, en && (e == n)};
            n_chk++;
            if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done} !== exp)
               $display("FAIL rand_count[%0d] n=%0d e=%0d got=%h want=%h", it, n, e,
                        {tif.cnt_o, tif.cnt_busy, tif.cnt_done}, exp);
            else n_pass++;
         end
         n_chk++;
         if (e != n) $display("FAIL rand_budget[%0d] got=%0d want=%0d", it, e, n);
         else n_pass++;
         cleanup();
      end
   endtask

   task automatic test_max();
      int cyc;
      load(W'(255));
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      cyc = 1;
      while (tif.cnt_done !== 1'b1 && cyc < 300) begin
         step();
         cyc++;
      end
      n_chk++;
      if (cyc != 256 || tif.cnt_o !== W'(0))
         $display("FAIL max_load got=%0d cnt=%0d want=256 cnt=0", cyc, tif.cnt_o);
      else n_pass++;
      cleanup();
   endtask

`ifdef CNT_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      logic [W+1:0] exp;
      load(W'(3));
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp = {W'(2 - ((k - 1) % 3)), 1'b1, ((k % 3) == 0)};
         n_chk++;
         if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done} !== exp)
            $display("FAIL auto_reload[%0d] got=%h want=%h", k,
                     {tif.cnt_o, tif.cnt_busy, tif.cnt_done}, exp);
         else n_pass++;
      end
      cleanup();
   endtask
`endif

   task automatic test_async_reset();
      load(W'(5));
      tif.cnt_start = 1'b1;
      tif.cnt_en    = 1'b1;
      step();
      tif.cnt_start = 1'b0;
      step();
      rst_n = 1'b0;
      #2;
      n_chk++;
      if ({tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready} !== {W'(0), 3'b001})
         $display("FAIL async_reset got=%h want=%h",
                  {tif.cnt_o, tif.cnt_busy, tif.cnt_done, tif.cnt_load_ready}, {W'(0), 3'b001});
      else n_pass++;
      idle_inputs();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
`ifdef CNT_AUTO_RELOAD_EN
      auto_rl = 1'b1;
`else
      auto_rl = 1'b0;
`endif
      test_reset();
      test_basic();
      test_pause();
      test_zero();
      test_abort();
      test_load_start();
      test_random();
      test_max();
`ifdef CNT_AUTO_RELOAD_EN
      test_auto_reload();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
